// File: rtl/common_pkg.sv
// Shared helpers for credit-flow blocks: credit-counter sizing,
// overflow detection and parameter range checks.
package common_pkg;

  // Credit counters use the logic [$clog2(N+1)-1:0] pattern; this keeps it in one place.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic logic credit_overflow(input logic ret, input logic accept,
                                           input logic at_max);
    return ret && !accept && at_max;
  endfunction

  function automatic bit param_ok(input int value, input int min_value);
    return value >= min_value;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Clock-enabled shift register, N stages of W bits, synchronous reset to zero.
module shift_reg #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) r_stage[k] <= '0;
    end else if (en) begin
      r_stage[0] <= d;
      for (int k = 1; k < N; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign q = r_stage[N-1];

endmodule

// File: rtl/credit_tx.sv
// Credit-flow link transmitter: valid-ready in, valid-only out, credit tracking.
// Define CREDIT_TX_REG_OUT_EN to register {o_v, o} (one cycle latency).
module credit_tx
  import common_pkg::*;
#(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_v,
  output logic                i_rdy,
  input  logic [W-1:0]        i,
  output logic                o_v,
  output logic [W-1:0]        o,
  input  logic                cr_v,
  output logic [cnt_w(N)-1:0] credits,
  output logic                err
);

  if (!param_ok(W, 1)) begin : g_bad_w
    $error("credit_tx: W must be >= 1");
  end
  if (!param_ok(N, 1)) begin : g_bad_n
    $error("credit_tx: N must be >= 1");
  end

  localparam int CW = cnt_w(N);
  typedef logic [CW-1:0] credit_t;
  localparam credit_t CMAX = credit_t'(N);
  localparam credit_t CONE = credit_t'(1);

  credit_t r_credits;
  logic    r_err;
  logic    w_accept;
  logic    w_ret;
  logic    w_at_max;

  // Reset gates both events so nothing is accepted or returned in a reset cycle.
  assign i_rdy    = (r_credits != '0);
  assign w_accept = i_v && i_rdy && clk_en && !rst;
  assign w_ret    = cr_v && clk_en && !rst;
  assign w_at_max = (r_credits == CMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= CMAX;
      r_err     <= 1'b0;
    end else begin
      if (credit_overflow(w_ret, w_accept, w_at_max)) r_err <= 1'b1;
      if (w_accept && !w_ret) begin
        r_credits <= r_credits - CONE;
      end else if (w_ret && !w_accept && !w_at_max) begin
        r_credits <= r_credits + CONE;
      end
    end
  end

  assign credits = r_credits;
  assign err     = r_err;

`ifdef CREDIT_TX_REG_OUT_EN
  logic [W:0] w_sr_d;
  logic [W:0] w_sr_q;

  // The data field only reloads on accept, otherwise it recirculates.
  assign w_sr_d = {w_accept, (w_accept ? i : w_sr_q[W-1:0])};

  shift_reg #(
    .W(W + 1),
    .N(1)
  ) u_out_reg (
    .clk(clk),
    .rst(rst),
    .en (clk_en),
    .d  (w_sr_d),
    .q  (w_sr_q)
  );

  assign o_v = w_sr_q[W];
  assign o   = w_sr_q[W-1:0];
`else
  assign o_v = w_accept;
  assign o   = i;
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx (W=8, N=4), directed scenarios plus
// randomized traffic against a cycle-level credit/queue reference model.
module tb_credit_tx;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);
`ifdef CREDIT_TX_REG_OUT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic          i_v = 1'b0;
  logic          cr_v = 1'b0;
  logic [W-1:0]  i = '0;
  logic          i_rdy;
  logic          o_v;
  logic [W-1:0]  o;
  logic [CW-1:0] credits;
  logic          err;

  always #5 clk = ~clk;

  credit_tx #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .i_v    (i_v),
    .i_rdy  (i_rdy),
    .i      (i),
    .o_v    (o_v),
    .o      (o),
    .cr_v   (cr_v),
    .credits(credits),
    .err    (err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: credit count, sticky error, pending registered beat.
  int         m_cred = N;
  bit         m_err = 1'b0;
  bit         m_rv = 1'b0;
  logic [7:0] m_ro = '0;
  // Inputs applied in the current cycle and whether the model accepts them.
  bit         p_cr = 1'b0, p_en = 1'b0, p_rst = 1'b1, p_acc = 1'b0;
  logic [7:0] p_d = '0;
  // Expected output beat for the current cycle.
  bit         e_ov;
  logic [7:0] e_o;

  // Advance one clock (updating the model from last cycle's inputs), drive new
  // inputs, then wait to the falling edge where outputs are sampled.
  task automatic apply(input bit v, input logic [7:0] d, input bit cr,
                       input bit en, input bit r);
    @(posedge clk);
    if (p_rst) begin
      m_cred = N; m_err = 1'b0; m_rv = 1'b0; m_ro = '0;
    end else if (p_en) begin
      if (p_acc && !p_cr) m_cred = m_cred - 1;
      else if (p_cr && !p_acc) begin
        if (m_cred == N) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
      m_rv = p_acc;
      if (p_acc) m_ro = p_d;
    end
    #1;
    i_v = v; i = d; cr_v = cr; clk_en = en; rst = r;
    p_d = d; p_cr = cr; p_en = en; p_rst = r;
    p_acc = v && (m_cred != 0) && en && !r;
    if (REG) begin e_ov = m_rv; e_o = m_ro; end
    else     begin e_ov = p_acc; e_o = d; end
    @(negedge clk);
    if (e_ov) $display("tx: beat item=%02h credits=%0d", e_o, m_cred);
  endtask

  task automatic test_reset();
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors += 4;
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL reset_credits: got %0d want 4", credits); end
    if (i_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_i_rdy: got %b want 1", i_rdy); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    if (o_v !== 1'b0) begin miscompares++; $display("FAIL reset_o_v: got %b want 0", o_v); end
  endtask

  task automatic test_exhaust();
    logic [7:0] items [5];
    logic [7:0] want [4];
    logic [7:0] obs [$];
    items = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    want  = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, items[(k < 5) ? k : 4], 1'b0, 1'b1, 1'b0);
      if (o_v === 1'b1) obs.push_back(o);
      vectors++;
      if (credits !== CW'(m_cred)) begin miscompares++; $display("FAIL exhaust_credits[%0d]: got %0d want %0d", k, credits, m_cred); end
    end
    vectors += 3;
    if (obs.size() != 4) begin miscompares++; $display("FAIL exhaust_beats: got %0d want 4", obs.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== want[k]) begin miscompares++; $display("FAIL exhaust_item[%0d]: got %02h want %02h", k, obs[k], want[k]); end
      end
    end
    if (credits !== CW'(0)) begin miscompares++; $display("FAIL exhaust_final_credits: got %0d want 0", credits); end
    if (i_rdy !== 1'b0) begin miscompares++; $display("FAIL exhaust_i_rdy: got %b want 0", i_rdy); end
  endtask

  task automatic test_return();
    logic [7:0] obs [$];
    apply(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    if (o_v === 1'b1) obs.push_back(o);
    apply(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    if (o_v === 1'b1) obs.push_back(o);
    vectors += 2;
    if (credits !== CW'(1)) begin miscompares++; $display("FAIL return_credits: got %0d want 1", credits); end
    if (i_rdy !== 1'b1) begin miscompares++; $display("FAIL return_i_rdy: got %b want 1", i_rdy); end
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    if (o_v === 1'b1) obs.push_back(o);
    vectors += 2;
    if (credits !== CW'(0)) begin miscompares++; $display("FAIL return_credits_after: got %0d want 0", credits); end
    if (obs.size() != 1 || obs[0] !== 8'h55) begin
      miscompares++;
      $display("FAIL return_beat: got %0d beats first=%02h want 1 beat 55", obs.size(), (obs.size() > 0) ? obs[0] : 8'hxx);
    end
  endtask

  task automatic test_simul();
    logic [7:0] sent [$];
    logic [7:0] obs [$];
    logic [7:0] d;
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      if (k < 3) begin
        apply(1'b1, d, 1'b1, 1'b1, 1'b0);
        sent.push_back(d);
      end else apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      if (o_v === 1'b1) obs.push_back(o);
      vectors++;
      if (credits !== CW'(2)) begin miscompares++; $display("FAIL simul_credits[%0d]: got %0d want 2", k, credits); end
    end
    vectors++;
    if (obs.size() != 3) begin miscompares++; $display("FAIL simul_beats: got %0d want 3", obs.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs[k] !== sent[k]) begin miscompares++; $display("FAIL simul_item[%0d]: got %02h want %02h", k, obs[k], sent[k]); end
      end
    end
  endtask

  task automatic test_overflow();
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    vectors += 2;
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL ovf_pre_credits: got %0d want 4", credits); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL ovf_pre_err: got %b want 0", err); end
    for (int k = 0; k < 3; k++) begin
      apply(k == 1, 8'h5A, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL ovf_err_sticky[%0d]: got %b want 1", k, err); end
    end
    vectors++;
    if (credits !== CW'(3)) begin miscompares++; $display("FAIL ovf_credits_saturated: got %0d want 3", credits); end
  endtask

  task automatic test_stall();
    int c0;
    bit e0;
    for (int pass = 0; pass < 2; pass++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      c0 = m_cred;
      e0 = m_err;
      for (int k = 0; k < 3; k++) begin
        apply(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        vectors += 3;
        if (credits !== CW'(c0)) begin miscompares++; $display("FAIL stall_credits[%0d]: got %0d want %0d", k, credits, c0); end
        if (err !== e0) begin miscompares++; $display("FAIL stall_err[%0d]: got %b want %b", k, err, e0); end
        if (o_v !== 1'b0) begin miscompares++; $display("FAIL stall_o_v[%0d]: got %b want 0", k, o_v); end
      end
      apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (credits !== CW'(c0)) begin miscompares++; $display("FAIL stall_after_credits: got %0d want %0d", credits, c0); end
      if (pass == 0) begin
        apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        vectors += 2;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_cleared_by_rst: got %b want 0", err); end
        if (credits !== CW'(4)) begin miscompares++; $display("FAIL rst_credits: got %0d want 4", credits); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    apply(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 8'hBB, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (o_v !== e_ov) begin miscompares++; $display("FAIL midrst_o_v: got %b want %b", o_v, e_ov); end
    apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    vectors += 3;
    if (o_v !== 1'b0) begin miscompares++; $display("FAIL midrst_after_o_v: got %b want 0", o_v); end
    if (credits !== CW'(4)) begin miscompares++; $display("FAIL midrst_credits: got %0d want 4", credits); end
    if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b want 0", err); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
      vectors += 4;
      if (credits !== CW'(m_cred)) begin miscompares++; $display("FAIL rand_credits[%0d]: got %0d want %0d", k, credits, m_cred); end
      if (i_rdy !== (m_cred != 0)) begin miscompares++; $display("FAIL rand_i_rdy[%0d]: got %b want %b", k, i_rdy, m_cred != 0); end
      if (err !== m_err) begin miscompares++; $display("FAIL rand_err[%0d]: got %b want %b", k, err, m_err); end
      if (o_v !== e_ov) begin miscompares++; $display("FAIL rand_o_v[%0d]: got %b want %b", k, o_v, e_ov); end
      if (e_ov) begin
        vectors++;
        if (o !== e_o) begin miscompares++; $display("FAIL rand_o[%0d]: got %02h want %02h", k, o, e_o); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_return();
    test_simul();
    test_overflow();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/credit_tx.md
CREDIT_TX -- requirements
Module: credit_tx

Purpose: the sending end of a credit-flow link into a remote valid-ready queue of known depth. Upstream valid-ready is converted into a downstream valid-only stream, and returned credits are tracked.

Interface
REQ-001 SHALL have parameter W, default 1: item width in bits; must be >= 1 (checked at elaboration with the shared param checks).
REQ-002 SHALL have parameter N, default 1: initial and maximum credit count, i.e. remote buffer slots; must be >= 1.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port clk_en  in  1  clock enable; when low, no state changes.
REQ-006 SHALL have port i_v  in  1  upstream item valid.
REQ-007 SHALL have port i_rdy  out  1  upstream ready; high iff credits != 0.
REQ-008 SHALL have port i  in  W  upstream item.
REQ-009 SHALL have port o_v  out  1  downstream item valid, one cycle per item, no backpressure.
REQ-010 SHALL have port o  out  W  downstream item.
REQ-011 SHALL have port cr_v  in  1  credit return, one credit per cycle high.
REQ-012 SHALL have port credits  out  $clog2(N+1)  current credit count.
REQ-013 SHALL have port err  out  1  sticky credit-overflow error.

Function
REQ-014 SHALL define accept = i_v && i_rdy && clk_en.
REQ-015 SHALL define ret = cr_v && clk_en.
REQ-016 SHALL update credits on posedge clk as follows:
- accept && !ret: credits - 1
- ret && !accept: credits + 1
- both or neither: unchanged.
REQ-017 SHALL keep credits in range 0..N; because i_rdy is low at 0, credits never underflow.
REQ-018 SHALL, when ret && !accept && credits == N:
- hold credits at N (saturate);
- set err on that edge;
- keep err high until reset.
REQ-019 SHALL not let an upstream item wait on cr_v: i_rdy depends only on registered credits, not on cr_v in the same cycle.
REQ-020 SHALL emit exactly one o_v beat per accepted item, in acceptance order, with no drops or duplicates.
REQ-021 SHALL leave o unspecified when o_v is low; verification must not check it then.
REQ-022 SHALL ignore i_v, cr_v and i entirely while clk_en is low.

Reset
REQ-023 SHALL, on rst high at posedge clk:
- set credits = N, err = 0, o_v = 0, o = 0;
- drop any accept or credit return in that cycle.
REQ-024 SHALL give rst priority over clk_en.
REQ-025 SHALL abandon any registered in-flight item when reset is asserted mid-stream; o_v is low in the next cycle.

Configuration
REQ-026 SHALL compile a registered output stage when macro CREDIT_TX_REG_OUT_EN is defined:
- o_v <= accept and o <= i (loaded only on accept), when clk_en is high;
- latency 1 cycle from accept to o_v;
- o_v and o hold their values while clk_en is low.
REQ-027 SHALL, without CREDIT_TX_REG_OUT_EN, drive o_v = accept and o = i combinationally (latency 0).
REQ-028 SHALL use identical credit and err behaviour in both configurations.

Structure
REQ-029 SHALL place the credit-count typedef (logic [$clog2(N+1)-1:0] pattern) and the credit-overflow helper in common_pkg; there is no block-local package.
REQ-030 SHALL implement the optional output register as an instance of the existing shift_reg (N=1) holding {o_v, o}, clock-enabled by clk_en.
REQ-031 SHALL use no further sub-modules; the credit counter is inline.

Verification (W=8, N=4, both macro settings)
REQ-032 SHALL cover reset values: rst high for 1 cycle -> credits=4, i_rdy=1, err=0, o_v=0.
REQ-033 SHALL cover credit exhaustion:
- stimulus: i_v high with items 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles, cr_v low;
- response: 4 o_v beats carrying 0x11..0x44;
- credits then = 0, i_rdy = 0, and 0x55 is held upstream.
REQ-034 SHALL cover credit return after exhaustion:
- stimulus: cr_v pulse for 1 cycle;
- response: next cycle credits = 1, i_rdy = 1, 0x55 accepted, credits back to 0.
REQ-035 SHALL cover simultaneous accept and return:
- stimulus: at credits = 2, i_v and cr_v high together for 3 cycles;
- response: credits stays 2; 3 o_v beats.
REQ-036 SHALL cover overflow:
- stimulus: at credits = 4, cr_v high for 1 cycle with no accept;
- response: credits = 4, err = 1, err stays set until rst.
REQ-037 SHALL cover clk_en stall: clk_en low for 3 cycles with i_v and cr_v high -> credits and err unchanged, no new o_v beat.
